// File: rtl/udp_rx_checksum_check_if.sv
// Receive byte stream from the MAC into the UDP checksum checker.
interface udp_rx_checksum_check_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;

  modport master (output in_valid, in_data, in_last);
  modport slave  (input  in_valid, in_data, in_last);
endinterface

// File: rtl/udp_rx_checksum_check.sv
// UDP receive checksum checker: captures pseudo-header fields from an
// Ethernet/IPv4/UDP byte stream, sums the UDP datagram and reports a verdict.
module udp_rx_checksum_check #(
  parameter int UDP_START = 34,
  parameter int IDX_W     = 16
) (
  input  logic                    clk_i,
  input  logic                    clear_i,
  udp_rx_checksum_check_if.slave  rx_if,
  output logic                    rx_done_o,
  output logic                    rx_ok_o,
  output logic                    rx_err_o,
  output logic                    rx_not_udp_o,
  output logic                    rx_nochk_o,
  output logic [15:0]             rx_udp_len_o
);

  typedef enum logic [2:0] {IDLE, HDR, SUM, FOLD1, FOLD2, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q;
  logic [15:0]       etype_q;
  logic [7:0]        proto_q;
  logic [31:0]       src_q, dst_q;
  logic [15:0]       udp_len_q, chk_q;
  logic [7:0]        msb_q;
  logic              pend_q;
  logic [31:0]       acc_q;
  logic              ok_q, err_q, not_udp_q, nochk_q;

  logic              accept;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [31:0]       idx32, off32, len32, rcvd32;
  logic              sum_en;
  logic [31:0]       sum_full, fold1;
  logic [16:0]       fold2;
  logic              runt, not_udp, len_bad;

  // Byte indexing, summing window and fold arithmetic.
  always_comb begin
    accept   = rx_if.in_valid && (state_q == IDLE || state_q == HDR || state_q == SUM);
    idx      = (state_q == IDLE) ? '0 : cnt_q;
    idx_nxt  = (&idx) ? idx : idx + 1'b1;
    idx32    = 32'(idx);
    off32    = idx32 - 32'(UDP_START);
    len32    = {16'd0, udp_len_q};
    // The first 8 UDP bytes are always summed; length is only known after byte 39.
    sum_en   = accept && (idx32 >= 32'(UDP_START)) && (off32 < 32'd8 || off32 < len32);
    sum_full = acc_q + {16'd0, src_q[31:16]} + {16'd0, src_q[15:0]}
             + {16'd0, dst_q[31:16]} + {16'd0, dst_q[15:0]}
             + 32'h0000_0011 + len32
             + (pend_q ? {16'd0, msb_q, 8'h00} : 32'd0);
    fold1    = {16'd0, sum_full[31:16]} + {16'd0, sum_full[15:0]};
    fold2    = {1'b0, acc_q[31:16]} + {1'b0, acc_q[15:0]};
    rcvd32   = 32'(cnt_q) - 32'(UDP_START);
    runt     = 32'(cnt_q) < 32'(UDP_START + 8);
    not_udp  = (etype_q != 16'h0800) || (proto_q != 8'h11);
    len_bad  = (udp_len_q < 16'd8) || (len32 > rcvd32);
  end

  // Next-state logic; in_last closes the frame from any receiving state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (rx_if.in_valid) state_d = rx_if.in_last ? FOLD1 : HDR;
      HDR:   if (rx_if.in_valid) begin
               if (rx_if.in_last)               state_d = FOLD1;
               else if (idx32 == 32'(UDP_START)) state_d = SUM;
             end
      SUM:   if (rx_if.in_valid && rx_if.in_last) state_d = FOLD1;
      FOLD1: state_d = FOLD2;
      FOLD2: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (clear_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Field capture, accumulation, folding and verdict registers.
  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      cnt_q     <= '0;
      etype_q   <= '0;
      proto_q   <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      udp_len_q <= '0;
      chk_q     <= '0;
      msb_q     <= '0;
      pend_q    <= 1'b0;
      acc_q     <= '0;
      ok_q      <= 1'b0;
      err_q     <= 1'b0;
      not_udp_q <= 1'b0;
      nochk_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q <= idx_nxt;
        if (state_q == IDLE) begin
          acc_q     <= '0;
          pend_q    <= 1'b0;
          udp_len_q <= '0;
          chk_q     <= '0;
          ok_q      <= 1'b0;
          err_q     <= 1'b0;
          not_udp_q <= 1'b0;
          nochk_q   <= 1'b0;
        end
        if (idx32 == 32'd12) etype_q[15:8] <= rx_if.in_data;
        if (idx32 == 32'd13) etype_q[7:0]  <= rx_if.in_data;
        if (idx32 == 32'd23) proto_q       <= rx_if.in_data;
        if (idx32 == 32'd26) src_q[31:24]  <= rx_if.in_data;
        if (idx32 == 32'd27) src_q[23:16]  <= rx_if.in_data;
        if (idx32 == 32'd28) src_q[15:8]   <= rx_if.in_data;
        if (idx32 == 32'd29) src_q[7:0]    <= rx_if.in_data;
        if (idx32 == 32'd30) dst_q[31:24]  <= rx_if.in_data;
        if (idx32 == 32'd31) dst_q[23:16]  <= rx_if.in_data;
        if (idx32 == 32'd32) dst_q[15:8]   <= rx_if.in_data;
        if (idx32 == 32'd33) dst_q[7:0]    <= rx_if.in_data;
        if (idx32 == 32'(UDP_START + 4)) udp_len_q[15:8] <= rx_if.in_data;
        if (idx32 == 32'(UDP_START + 5)) udp_len_q[7:0]  <= rx_if.in_data;
        if (idx32 == 32'(UDP_START + 6)) chk_q[15:8]     <= rx_if.in_data;
        if (idx32 == 32'(UDP_START + 7)) chk_q[7:0]      <= rx_if.in_data;
        // Even offsets park the MSB; odd offsets complete the 16-bit word.
        if (sum_en) begin
          if (!off32[0]) begin
            msb_q  <= rx_if.in_data;
            pend_q <= 1'b1;
          end else begin
            acc_q  <= acc_q + {16'd0, msb_q, rx_if.in_data};
            pend_q <= 1'b0;
          end
        end
      end
      if (state_q == FOLD1) begin
        acc_q  <= fold1;
        pend_q <= 1'b0;
      end
      if (state_q == FOLD2) begin
        ok_q      <= 1'b0;
        err_q     <= 1'b0;
        not_udp_q <= 1'b0;
        nochk_q   <= 1'b0;
        if (runt)                       err_q     <= 1'b1;
        else if (not_udp)               not_udp_q <= 1'b1;
        else if (len_bad)               err_q     <= 1'b1;
        else if (chk_q == 16'h0000)     begin ok_q <= 1'b1; nochk_q <= 1'b1; end
        else if (fold2[15:0] == 16'hFFFF) ok_q  <= 1'b1;
        else                            err_q     <= 1'b1;
      end
    end
  end

  assign rx_done_o    = (state_q == DONE);
  assign rx_ok_o      = ok_q;
  assign rx_err_o     = err_q;
  assign rx_not_udp_o = not_udp_q;
  assign rx_nochk_o   = nochk_q;
  assign rx_udp_len_o = udp_len_q;

endmodule

// File: doc/udp_rx_checksum_check.md
Name: udp_rx_checksum_check

Overview:
- Receive-side counterpart of the transmit checksum generator.
- Consumes an incoming Ethernet/IPv4/UDP frame one byte per cycle, with the byte index starting at 0 on the first byte of the Ethernet header.
- Captures the pseudo-header fields, accumulates the one's-complement sum over the UDP header and payload, and reports pass or fail once per frame.
- Sits between the MAC receive byte stream and the UDP payload consumer; the consumer gates on rx_ok.

Parameters:
- UDP_START, 34, byte index of the first UDP header byte.
- IDX_W, 16, width of the internal byte counter (saturates, never wraps).

Ports:
- clk  input  1  clock; all state updates on posedge.
- clear  input  1  synchronous active-high reset; also aborts any frame in progress.
- in_valid  input  1  in_data carries a frame byte this cycle.
- in_data  input  8  frame byte.
- in_last  input  1  qualifies the final byte of the frame; valid only with in_valid.
- rx_done  output  1  one-cycle pulse when the verdict is available.
- rx_ok  output  1  checksum verified, or checksum field was 0x0000; held until the next frame starts.
- rx_err  output  1  checksum mismatch, runt frame, or UDP length inconsistent; held like rx_ok.
- rx_not_udp  output  1  EtherType != 0x0800 or IP protocol != 0x11; held like rx_ok.
- rx_nochk  output  1  received UDP checksum field was 0x0000.
- rx_udp_len  output  16  captured UDP length field.

Behaviour:
- Reset (clear=1): state=IDLE, byte counter=0, accumulator=0. Outputs rx_done, rx_ok, rx_err, rx_not_udp, rx_nochk = 0; rx_udp_len = 0.
- Byte index = counter value at the in_valid cycle. The counter increments only on in_valid and saturates at all-ones.
- Captured fields:
  - EtherType: bytes 12-13.
  - IP protocol: byte 23.
  - IP source: bytes 26-29.
  - IP destination: bytes 30-33.
  - UDP length: bytes 38-39.
  - UDP checksum: bytes 40-41.
- Summed bytes: index UDP_START .. UDP_START+udp_len-1 only, including the checksum field itself. Ethernet pad bytes beyond udp_len are ignored.
- Byte pairing: even offsets from UDP_START form the MSB, odd offsets the LSB; the pair is added to a 32-bit accumulator on the LSB byte. An odd-length tail is padded with a 0x00 LSB.
- Pseudo-header: src[31:16] + src[15:0] + dst[31:16] + dst[15:0] + 0x0011 + udp_len, added in the FOLD state.
- States:
  - IDLE: first in_valid byte moves to HDR; the counter restarts at 0 on that byte. Held verdict outputs clear on this byte.
  - HDR: captures header fields. At index UDP_START moves to SUM.
  - SUM: accumulates bytes.
  - FOLD1: adds the pseudo-header, then sum = sum[31:16] + sum[15:0].
  - FOLD2: second fold and compare.
  - DONE: pulses rx_done, returns to IDLE.
- in_last ends the frame in whichever state it arrives. HDR or SUM go to FOLD1.
- Latency: rx_done asserts exactly 3 cycles after the in_last cycle; in_last takes the state to FOLD1, then FOLD2, then DONE, where rx_done pulses.
- Verdict priority, highest first; exactly one of rx_ok/rx_err/rx_not_udp is set at rx_done:
  1. Frame ended before byte 41 → rx_err.
  2. EtherType or protocol mismatch → rx_not_udp.
  3. udp_len < 8 or udp_len > bytes received from UDP_START → rx_err.
  4. Checksum field == 0x0000 → rx_ok=1, rx_nochk=1.
  5. Folded 16-bit sum == 0xFFFF → rx_ok, else rx_err.
- in_valid is ignored during FOLD1, FOLD2 and DONE; upstream guarantees an inter-frame gap of at least 3 cycles.
- clear mid-frame discards all state; the next in_valid byte is treated as byte 0.
- Simultaneous clear and in_last: clear wins and no rx_done is issued.

Test Plan:
- Valid frame, udp_len=0x001A, checksum from golden model (transmit generator output) → rx_done 3 cycles after in_last, rx_ok=1, rx_err=0, rx_udp_len=0x001A.
- Same frame with payload byte 44 bit 0 flipped → rx_err=1, rx_ok=0.
- Odd udp_len=0x0009 (1 payload byte 0xAB, golden checksum), padded to a 60-byte frame with 0x55 pad bytes → rx_ok=1 (pad ignored, tail padded 0xAB00).
- Checksum bytes 40-41 = 0x0000 with a corrupted payload → rx_ok=1, rx_nochk=1.
- EtherType 0x0806 frame of 60 bytes → rx_not_udp=1. A 30-byte frame ending with in_last → rx_err=1.
- clear asserted at byte 20 of frame A, then full valid frame B → exactly one rx_done, rx_ok=1, for B only.
